truth_table_checker: RTL and testbench

Synthesizable response checker for 3-input/3-output combinational blocks. It accepts applied input vectors {a,b,c} through a valid/ready handshake, waits a programmable settle interval, and samples the DUT outputs {d,e,f}. Each sample is compared against a parameterized expected truth table. The block tracks input-space coverage, pass and fail counts, and the first mismatch, then flags completion once all 8 input combinations have been checked. It sits on the monitor side of the stimulus path and replaces manual waveform inspection in hardware bring-up.

---
 rtl/truth_table_checker.sv | 161 ++++++++++++++++
 tb/tb_truth_table_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Response checker for 3-in/3-out combinational blocks.
// Compares sampled responses against a truth table and tracks coverage.
module truth_table_checker #(
  parameter logic [23:0] EXPECTED      = 24'h9900D1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vec_valid,
  input  logic [2:0] vec_in,
  output logic       vec_ready,
  input  logic [2:0] resp_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] check_count,
  output logic [7:0] fail_count,
  output logic [7:0] cover_map,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec,
  output logic [2:0] first_fail_resp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nx;
  logic [2:0] r_vec;
  logic [2:0] w_vec_nx;
  logic [7:0] r_cc;
  logic [7:0] w_cc_nx;
  logic [7:0] r_fc;
  logic [7:0] w_fc_nx;
  logic [7:0] r_cov;
  logic [7:0] w_cov_nx;
  logic       r_ffv;
  logic       w_ffv_nx;
  logic [2:0] r_ffvec;
  logic [2:0] w_ffvec_nx;
  logic [2:0] r_ffresp;
  logic [2:0] w_ffresp_nx;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] w_exp;
  logic       w_mis;
  logic [7:0] w_cov_upd;

  assign w_exp     = EXPECTED[32'(r_vec) * 3 +: 3];
  assign w_mis     = (resp_in != w_exp);
  assign w_cov_upd = r_cov | (8'd1 << r_vec);

  // Next-state and next-result computation
  always_comb begin
    w_next      = r_state;
    w_cnt_nx    = r_cnt;
    w_vec_nx    = r_vec;
    w_cc_nx     = r_cc;
    w_fc_nx     = r_fc;
    w_cov_nx    = r_cov;
    w_ffv_nx    = r_ffv;
    w_ffvec_nx  = r_ffvec;
    w_ffresp_nx = r_ffresp;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next      = S_RUN;
          w_cc_nx     = 8'd0;
          w_fc_nx     = 8'd0;
          w_cov_nx    = 8'd0;
          w_ffv_nx    = 1'b0;
          w_ffvec_nx  = 3'd0;
          w_ffresp_nx = 3'd0;
        end
      end
      S_RUN: begin
        if (vec_valid) begin
          w_next   = S_SETTLE;
          w_vec_nx = vec_in;
          w_cnt_nx = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_cov_nx = w_cov_upd;
          if (r_cc != 8'hFF)
            w_cc_nx = r_cc + 8'd1;
          if (w_mis) begin
            if (r_fc != 8'hFF)
              w_fc_nx = r_fc + 8'd1;
            if (!r_ffv) begin
              w_ffv_nx    = 1'b1;
              w_ffvec_nx  = r_vec;
              w_ffresp_nx = resp_in;
            end
          end
          w_next = (w_cov_upd == 8'hFF) ? S_DONE : S_RUN;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_vec    <= 3'd0;
      r_cc     <= 8'd0;
      r_fc     <= 8'd0;
      r_cov    <= 8'd0;
      r_ffv    <= 1'b0;
      r_ffvec  <= 3'd0;
      r_ffresp <= 3'd0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nx;
      r_vec    <= w_vec_nx;
      r_cc     <= w_cc_nx;
      r_fc     <= w_fc_nx;
      r_cov    <= w_cov_nx;
      r_ffv    <= w_ffv_nx;
      r_ffvec  <= w_ffvec_nx;
      r_ffresp <= w_ffresp_nx;
      r_ready  <= (w_next == S_RUN);
      r_busy   <= (w_next == S_RUN) || (w_next == S_SETTLE);
      r_done   <= (w_next == S_DONE);
      r_pass   <= (w_next == S_DONE) && (w_fc_nx == 8'd0);
    end
  end

  assign vec_ready        = r_ready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign check_count      = r_cc;
  assign fail_count       = r_fc;
  assign cover_map        = r_cov;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;
  assign first_fail_resp  = r_ffresp;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker.
// Instance 0 settles 2 cycles, instance 1 settles 0 cycles.
module tb_truth_table_checker;

  typedef struct packed {
    logic [7:0] cc;
    logic [7:0] fc;
    logic [7:0] cov;
    logic       ffv;
    logic [2:0] fv;
    logic [2:0] fr;
    logic       done;
    logic       pass;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start [2];
  logic       vv    [2];
  logic [2:0] vin   [2];
  logic [2:0] rin   [2];
  logic       rdy   [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [7:0] cc    [2];
  logic [7:0] fc    [2];
  logic [7:0] cov   [2];
  logic       ffv   [2];
  logic [2:0] ffvec [2];
  logic [2:0] ffrsp [2];

  int errs;
  int checks;

  exp_t q0[$];
  exp_t q1[$];

  int         m_cc  [2];
  int         m_fc  [2];
  logic [7:0] m_cov [2];
  bit         m_ffv [2];
  logic [2:0] m_fv  [2];
  logic [2:0] m_fr  [2];

  bit   pb [2];
  bit   pr [2];
  exp_t e_m;
  exp_t g_m;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    truth_table_checker #(
      .EXPECTED     (24'h9900D1),
      .SETTLE_CYCLES((g == 0) ? 2 : 0)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start[g]),
      .vec_valid       (vv[g]),
      .vec_in          (vin[g]),
      .vec_ready       (rdy[g]),
      .resp_in         (rin[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .pass            (pass[g]),
      .check_count     (cc[g]),
      .fail_count      (fc[g]),
      .cover_map       (cov[g]),
      .first_fail_valid(ffv[g]),
      .first_fail_vec  (ffvec[g]),
      .first_fail_resp (ffrsp[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_resp(input logic [2:0] v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    return {a & b, b ^ c, ~(a | c)};
  endfunction

  function automatic exp_t dut_rec(input int g);
    exp_t r;
    r.cc   = cc[g];
    r.fc   = fc[g];
    r.cov  = cov[g];
    r.ffv  = ffv[g];
    r.fv   = ffvec[g];
    r.fr   = ffrsp[g];
    r.done = done[g];
    r.pass = pass[g];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear(input int g);
    m_cc[g]  = 0;
    m_fc[g]  = 0;
    m_cov[g] = 8'd0;
    m_ffv[g] = 1'b0;
    m_fv[g]  = 3'd0;
    m_fr[g]  = 3'd0;
  endtask

  task automatic model_step(input int g, input logic [2:0] v,
                            input logic [2:0] r);
    exp_t e;
    if (m_cc[g] < 255) m_cc[g]++;
    m_cov[g][v] = 1'b1;
    if (r != ref_resp(v)) begin
      if (m_fc[g] < 255) m_fc[g]++;
      if (!m_ffv[g]) begin
        m_ffv[g] = 1'b1;
        m_fv[g]  = v;
        m_fr[g]  = r;
      end
    end
    e.cc   = 8'(m_cc[g]);
    e.fc   = 8'(m_fc[g]);
    e.cov  = m_cov[g];
    e.ffv  = m_ffv[g];
    e.fv   = m_fv[g];
    e.fr   = m_fr[g];
    e.done = (m_cov[g] == 8'hFF);
    e.pass = (m_cov[g] == 8'hFF) && (m_fc[g] == 0);
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Pops one expectation per completed compare
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        pb[g] = 1'b0;
        pr[g] = 1'b0;
      end else begin
        if (pb[g] && !pr[g] && (rdy[g] || done[g])) begin
          g_m = dut_rec(g);
          checks++;
          if ((g == 0 ? q0.size() : q1.size()) == 0) begin
            errs++;
            $display("FAIL sb_empty dut%0d: got %0h", g, g_m);
          end else begin
            e_m = (g == 0) ? q0.pop_front() : q1.pop_front();
            if (g_m !== e_m) begin
              errs++;
              $display("FAIL compare dut%0d: got %0h want %0h",
                       g, g_m, e_m);
            end
          end
        end
        pb[g] = busy[g];
        pr[g] = rdy[g];
      end
    end
  end

  task automatic issue(input int g, input logic [2:0] v,
                       input logic [2:0] early, input logic [2:0] fin,
                       input int ecyc, output bit ok,
                       output time tacc);
    int n;
    n  = 0;
    ok = 1'b0;
    tacc = 0;
    @(negedge clk);
    while (!rdy[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[g]) begin
      chk("rdy_timeout", 64'(rdy[g]), 64'd1);
      return;
    end
    model_step(g, v, fin);
    vv[g]  = 1'b1;
    vin[g] = v;
    rin[g] = early;
    @(posedge clk);
    tacc = $time;
    #1 vv[g] = 1'b0;
    repeat (ecyc) @(posedge clk);
    if (ecyc > 0) #1;
    rin[g] = fin;
    ok = 1'b1;
  endtask

  task automatic apply(input int g, input logic [2:0] v,
                       input logic [2:0] early, input logic [2:0] fin,
                       input int ecyc);
    bit  ok;
    time t;
    int  n;
    issue(g, v, early, fin, ecyc, ok, t);
    if (!ok) return;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rdy[g] || !busy[g]) && n < 300);
    chk("settle_len", 64'(($time - t - 5) / 10),
        64'((g == 0) ? 3 : 1));
  endtask

  task automatic good(input int g, input logic [2:0] v);
    apply(g, v, ref_resp(v), ref_resp(v), 0);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
    model_clear(g);
    chk("start_clear", {busy[g], cc[g], fc[g], cov[g], ffv[g]},
        {1'b1, 25'd0});
  endtask

  task automatic chk_all_zero(input int g, input string nm);
    chk(nm, {rdy[g], busy[g], done[g], pass[g], cc[g], fc[g], cov[g],
             ffv[g], ffvec[g], ffrsp[g]}, 64'd0);
  endtask

  initial begin
    logic [2:0] ord [8];
    logic [2:0] v;
    logic [2:0] tmp;
    int         j;
    bit         ok;
    time        t;
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      vv[g]    = 1'b0;
      vin[g]   = 3'd0;
      rin[g]   = 3'd0;
      model_clear(g);
    end
    #12;
    chk_all_zero(0, "reset0");
    chk_all_zero(1, "reset1");
    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive matching run
    pulse_start(0);
    for (int i = 0; i < 8; i++) good(0, 3'(i));
    chk("t1_done_pass", {done[0], pass[0]}, 2'b11);

    // single fault on vector 5, random order
    pulse_start(0);
    for (int i = 0; i < 8; i++) ord[i] = 3'(i);
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = ord[i];
      ord[i] = ord[j];
      ord[j] = tmp;
    end
    for (int i = 0; i < 8; i++) begin
      if (ord[i] == 3'd5) apply(0, 3'd5, 3'd7, 3'd7, 0);
      else good(0, ord[i]);
    end
    chk("t2_fault", {done[0], pass[0], fc[0], ffvec[0], ffrsp[0]},
        {2'b10, 8'd1, 3'd5, 3'd7});

    // repeats and ordering
    pulse_start(0);
    good(0, 3'd7);
    good(0, 3'd7);
    for (int i = 0; i < 7; i++) good(0, 3'(i));
    chk("t3_repeat", {done[0], cc[0]}, {1'b1, 8'd9});

    // random vectors with random faults until covered
    pulse_start(0);
    for (int i = 0; i < 80 && m_cov[0] != 8'hFF; i++) begin
      v = 3'($urandom_range(7, 0));
      if ($urandom_range(9, 0) < 3)
        apply(0, v, 3'($urandom), ~ref_resp(v), 0);
      else good(0, v);
    end
    chk("rand_done", 64'(done[0]), 64'd1);

    // settle timing: late-correct responses must pass
    pulse_start(1);
    for (int i = 0; i < 8; i++)
      apply(1, 3'(i), ~ref_resp(3'(i)), ref_resp(3'(i)), 0);
    chk("t4_s0", {done[1], pass[1], fc[1]}, {2'b11, 8'd0});
    pulse_start(0);
    for (int i = 0; i < 8; i++)
      apply(0, 3'(i), ~ref_resp(3'(i)), ref_resp(3'(i)), 2);
    chk("t4_s2", {done[0], pass[0], fc[0]}, {2'b11, 8'd0});

    // reset while settling
    pulse_start(0);
    for (int i = 0; i < 4; i++) good(0, 3'(i));
    issue(0, 3'd4, ref_resp(3'd4), ref_resp(3'd4), 0, ok, t);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero(0, "t5_rst0");
    chk_all_zero(1, "t5_rst1");
    q0.delete();
    q1.delete();
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle", {rdy[0], busy[0], done[0]}, 3'b000);

    // restart from DONE and saturate
    pulse_start(0);
    for (int i = 0; i < 8; i++) good(0, 3'(i));
    chk("t6_done", 64'(done[0]), 64'd1);
    pulse_start(0);
    for (int i = 0; i < 300; i++)
      apply(0, 3'd0, ~ref_resp(3'd0), ~ref_resp(3'd0), 0);
    chk("t6_sat", {done[0], cc[0], fc[0]}, {1'b0, 8'hFF, 8'hFF});

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
